decode_control: RTL
===================

// Module: decode_control
// PURPOSE
//  Instruction sequencer for the 4-bit CPU. Sits directly downstream of the Fetch register.
//  Consumes the latched 8-bit instruction (opcode[7:4], operand[3:0]). Drives Fetch's load enable.
//  Drives the PC's increment and load controls and the datapath write strobes.
//  Runs a small phase FSM: fetch, execute, and for jumps a second byte carrying the low 8 target bits.
// PARAMETERS
//  HALT_EN          1  1: opcode 0xF halts until reset; 0: 0xF is treated as reserved.
//  ILLEGAL_AS_HALT  0  1: a reserved opcode halts; 0: it executes as NOP.
// PORTS
//  clk            in   1   system clock, all state updates on rising edge
//  reset          in   1   asynchronous, active-high; clears FSM and all registers
//  instr          in   8   instruction byte from Fetch (out_fetch)
//  c_flag         in   1   carry flag from ALU flag register
//  z_flag         in   1   zero flag from ALU flag register
//  enabled_fetch  out  1   load enable to Fetch register
//  pc_inc         out  1   PC increment strobe
//  pc_load        out  1   PC parallel-load strobe
//  pc_addr        out  12  PC load value {addr_hi, instr}
//  alu_sel        out  3   0 PASS_B, 1 ADD, 2 SUB, 3 NAND
//  imm            out  4   operand nibble to ALU B input
//  acc_we         out  1   accumulator write enable
//  flags_we       out  1   C/Z flag register write enable
//  in_en          out  1   ALU B source = input port (else imm)
//  out_we         out  1   output port register write enable
//  illegal        out  1   one-cycle pulse on reserved opcode
//  halted         out  1   high while in HALT
// BEHAVIOUR
//  - Outputs: combinational from state; registers addr_hi[3:0] and take_jmp.
//  - Reset: state=IDLE, addr_hi=0, take_jmp=0. All outputs are 0 while reset is high and in IDLE.
//  - States and transitions:
//    IDLE->FETCH. IDLE lasts 1 cycle after reset release, with no strobes.
//    FETCH: enabled_fetch=1, pc_inc=1 -> EXEC.
//    EXEC: decode instr[7:4] and assert the controls below for exactly this cycle.
//      Non-jump opcode -> FETCH.
//      Jump opcode (0x8-0xC) -> ADDR; latch addr_hi<=instr[3:0]; latch take_jmp from the flags sampled this cycle.
//    ADDR: enabled_fetch=1, pc_inc=1 (fetches the low address byte).
//      -> JUMP if take_jmp=1, else -> FETCH.
//    JUMP: pc_load=1, pc_addr={addr_hi,instr} -> FETCH.
//    HALT: all strobes 0, halted=1; only reset leaves HALT.
//  - Opcode table (in EXEC):
//    0 NOP: no strobes.
//    1 LIT: alu_sel=0, acc_we=1.
//    2 IN: alu_sel=0, in_en=1, acc_we=1.
//    3 CMPI: alu_sel=2, flags_we=1.
//    4 ADDI: alu_sel=1, acc_we=1, flags_we=1.
//    5 NANDI: alu_sel=3, acc_we=1, flags_we=1.
//    6 SUBI: alu_sel=2, acc_we=1, flags_we=1.
//    7 OUT: out_we=1.
//    8 JC: take if c=1.
//    9 JNC: take if c=0.
//    A JZ: take if z=1.
//    B JNZ: take if z=0.
//    C JMP: always taken.
//    D,E reserved: illegal=1, then NOP or HALT per ILLEGAL_AS_HALT.
//    F HLT: -> HALT if HALT_EN=1, else handled as reserved.
//  - imm=instr[3:0] in every state. Outside EXEC, alu_sel=0 and all write strobes are 0.
//  - Latency: non-jump 2 cycles per instruction. Jump taken 4 cycles; jump not taken 3 cycles.
//  - Flags are sampled only in EXEC. A flag change during ADDR/JUMP does not alter the jump decision.
//  - pc_addr is 12 bits with no wrap logic here; the PC owns wrap-around (0xFFF+1 -> 0x000).
//  - Reset mid-operation (any state, any phase) returns to IDLE asynchronously.
//    No partial PC load or write strobe survives the reset edge.
//  - enabled_fetch and pc_load are never high in the same cycle. pc_inc and pc_load are mutually exclusive.
// TESTING
//  - Reset, then instr=0x15 -> IDLE 1 cycle; FETCH (enabled_fetch=1, pc_inc=1); EXEC (acc_we=1, alu_sel=0, imm=5); back to FETCH.
//  - CMPI: instr=0x3A -> flags_we=1, alu_sel=2, acc_we=0.
//    OUT: instr=0x70 -> out_we=1 only. Each strobe lasts exactly 1 cycle.
//  - JZ, z_flag=1: EXEC instr=0xA3; ADDR instr=0x4C -> JUMP asserts pc_load=1, pc_addr=0x34C. 4 cycles total.
//  - JC, c_flag=0: instr=0x81 -> ADDR then FETCH, pc_load never asserted. 3 cycles.
//    Toggling c_flag during ADDR changes nothing.
//  - instr=0xD0 -> illegal=1 for 1 cycle, then FETCH. instr=0xF0 with HALT_EN=1 -> halted=1, no strobes for 20 cycles.
//  - Assert reset during JUMP and during HALT -> outputs 0 immediately; after release, IDLE then FETCH.

Source files
------------

// File: rtl/decode_control.sv
// Instruction sequencer for the 4-bit CPU: steps through fetch/execute (plus address/jump
// phases for branches) and decodes the latched instruction into PC and datapath strobes.
module decode_control #(
  parameter logic HALT_EN         = 1'b1,
  parameter logic ILLEGAL_AS_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instr,
  input  logic        c_flag,
  input  logic        z_flag,
  output logic        enabled_fetch,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [11:0] pc_addr,
  output logic [2:0]  alu_sel,
  output logic [3:0]  imm,
  output logic        acc_we,
  output logic        flags_we,
  output logic        in_en,
  output logic        out_we,
  output logic        illegal,
  output logic        halted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    ADDR  = 3'd3,
    JUMP  = 3'd4,
    HALT  = 3'd5
  } state_t;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_SUB    = 3'd2;
  localparam logic [2:0] ALU_NAND   = 3'd3;

  state_t     state;
  logic [3:0] addr_hi;
  logic       take_jmp;

  logic [3:0] op;
  logic       is_jump;
  logic       is_hlt;
  logic       is_reserved;
  logic       cond;

  assign op          = instr[7:4];
  assign is_jump     = (op >= 4'h8) && (op <= 4'hC);
  assign is_hlt      = HALT_EN && (op == 4'hF);
  assign is_reserved = (op == 4'hD) || (op == 4'hE) || ((op == 4'hF) && !HALT_EN);

  // Branch condition; only consumed in EXEC, so later flag changes cannot redirect a jump.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cond = 1'b1;
    case (op)
      4'h8:    cond = c_flag;
      4'h9:    cond = !c_flag;
      4'hA:    cond = z_flag;
      4'hB:    cond = !z_flag;
      default: cond = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      addr_hi  <= 4'h0;
      take_jmp <= 1'b0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: state <= EXEC;
        EXEC: begin
          if (is_jump) begin
            state    <= ADDR;
            addr_hi  <= instr[3:0];
            take_jmp <= cond;
          end else if (is_hlt || (is_reserved && ILLEGAL_AS_HALT)) begin
            state <= HALT;
          end else begin
            state <= FETCH;
          end
        end
        ADDR:    state <= take_jmp ? JUMP : FETCH;
        JUMP:    state <= FETCH;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are pure decode of the current phase; IDLE (and therefore reset) drives everything low.
  always_comb begin
    enabled_fetch = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_addr       = 12'h000;
    alu_sel       = ALU_PASS_B;
    imm           = (state == IDLE) ? 4'h0 : instr[3:0];
    acc_we        = 1'b0;
    flags_we      = 1'b0;
    in_en         = 1'b0;
    out_we        = 1'b0;
    illegal       = 1'b0;
    halted        = 1'b0;
    case (state)
      FETCH, ADDR: begin
        enabled_fetch = 1'b1;
        pc_inc        = 1'b1;
      end
      JUMP: begin
        pc_load = 1'b1;
        pc_addr = {addr_hi, instr};
      end
      HALT: halted = 1'b1;
      EXEC: begin
        case (op)
          4'h1: acc_we = 1'b1;
          4'h2: begin
            in_en  = 1'b1;
            acc_we = 1'b1;
          end
          4'h3: begin
            alu_sel  = ALU_SUB;
            flags_we = 1'b1;
          end
          4'h4: begin
            alu_sel  = ALU_ADD;
            acc_we   = 1'b1;
            flags_we = 1'b1;
          end
          4'h5: begin
            alu_sel  = ALU_NAND;
            acc_we   = 1'b1;
            flags_we = 1'b1;
          end
          4'h6: begin
            alu_sel  = ALU_SUB;
            acc_we   = 1'b1;
            flags_we = 1'b1;
          end
          4'h7:    out_we  = 1'b1;
          default: illegal = is_reserved;
        endcase
      end
      default: ;
    endcase
  end

endmodule
